bus_xfer_sched: RTL and testbench

//  Shares one burst bus (valid/ready/done) between N_REQ requesters with round-robin arbitration.

---
 rtl/bus_xfer_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/bus_xfer_sched.sv | 203 ++++++++++++++++++++
 tb/tb_bus_xfer_sched.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_xfer_pkg.sv
// Shared types for the burst-bus transfer scheduler.
// Holds the FSM state encoding, error codes and counter width.
package bus_xfer_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        BURST,
        WAIT_DONE,
        CLOSE
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_RDY_TO,
        ERR_RDY_DROP,
        ERR_DONE_TO
    } err_code_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after ptr.
// Ports: req (requests), ptr (priority start) -> any, onehot, idx.
module rr_arbiter
    import bus_xfer_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     any,
    output logic [N_REQ-1:0]         onehot,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] cand;

    always_comb begin
        any    = 1'b0;
        onehot = '0;
        idx    = '0;
        cand   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // Wrap without a modulo so non-power-of-two N_REQ works.
            if (int'(ptr) + i >= N_REQ) begin
                cand = IDX_W'(int'(ptr) + i - N_REQ);
            end else begin
                cand = IDX_W'(int'(ptr) + i);
            end
            if (!any && req[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/bus_xfer_sched.sv
// Round-robin burst-bus scheduler: grants one requester, runs
// valid/ready beats, waits for done and reports errors.
// Ports: clk, rst_n, req -> gnt; valid/ready/done bus handshake;
// busy, xfer_ok, err, err_code, err_id status outputs.
module bus_xfer_sched
    import bus_xfer_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int BURST_LEN = 4,
    parameter int READY_TO  = 4,
    parameter int DONE_TO   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic                     valid,
    input  logic                     ready,
    input  logic                     done,
    output logic                     busy,
    output logic                     xfer_ok,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [$clog2(N_REQ)-1:0] err_id
);

    localparam int IDX_W = $clog2(N_REQ);

    localparam logic [CNT_W-1:0] BURST_C  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] RDY_TO_C = CNT_W'(READY_TO);
    localparam logic [CNT_W-1:0] DONE_C   = CNT_W'(DONE_TO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             xfer_ok_q, xfer_ok_d;
    logic             err_q, err_d;
    err_code_e        err_code_q, err_code_d;
    logic [IDX_W-1:0] err_id_q, err_id_d;

    logic             arb_any;
    logic [N_REQ-1:0] arb_onehot;
    logic [IDX_W-1:0] arb_idx;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .any    (arb_any),
        .onehot (arb_onehot),
        .idx    (arb_idx)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gidx_d     = gidx_q;
        ptr_d      = ptr_q;
        beat_d     = beat_q;
        valid_d    = valid_q;
        xfer_ok_d  = 1'b0;
        err_d      = 1'b0;
        err_code_d = ERR_NONE;
        err_id_d   = '0;
        // elapsed runs every cycle of a transfer and pins at DONE_TO.
        if (elapsed_q == DONE_C) begin
            elapsed_d = elapsed_q;
        end else begin
            elapsed_d = elapsed_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                elapsed_d = '0;
                beat_d    = '0;
                if (arb_any) begin
                    gnt_d     = arb_onehot;
                    gidx_d    = arb_idx;
                    elapsed_d = CNT_W'(1);
                    valid_d   = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (ready) begin
                    beat_d = CNT_W'(1);
                    if (BURST_LEN == 1) begin
                        valid_d = 1'b0;
                        state_d = WAIT_DONE;
                    end else begin
                        state_d = BURST;
                    end
                end else if (elapsed_q == RDY_TO_C) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_RDY_TO;
                    err_id_d   = gidx_q;
                    gnt_d      = '0;
                    valid_d    = 1'b0;
                    state_d    = CLOSE;
                end
            end
            BURST: begin
                if (ready) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_d == BURST_C) begin
                        valid_d = 1'b0;
                        state_d = WAIT_DONE;
                    end
                end else begin
                    err_d      = 1'b1;
                    err_code_d = ERR_RDY_DROP;
                    err_id_d   = gidx_q;
                    gnt_d      = '0;
                    valid_d    = 1'b0;
                    state_d    = CLOSE;
                end
            end
            WAIT_DONE: begin
                if (done) begin
                    xfer_ok_d = 1'b1;
                    gnt_d     = '0;
                    state_d   = CLOSE;
                end else if (elapsed_q == DONE_C) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_DONE_TO;
                    err_id_d   = gidx_q;
                    gnt_d      = '0;
                    state_d    = CLOSE;
                end
            end
            CLOSE: begin
                gnt_d   = '0;
                valid_d = 1'b0;
                if (gidx_q == LAST_IDX) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = gidx_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gidx_q     <= '0;
            ptr_q      <= '0;
            elapsed_q  <= '0;
            beat_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            xfer_ok_q  <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            err_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gidx_q     <= gidx_d;
            ptr_q      <= ptr_d;
            elapsed_q  <= elapsed_d;
            beat_q     <= beat_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            xfer_ok_q  <= xfer_ok_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_id_q   <= err_id_d;
        end
    end

    assign gnt      = gnt_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign xfer_ok  = xfer_ok_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign err_id   = err_id_q;

    a_gnt_onehot: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_valid_busy: assert property (
        @(posedge clk) disable iff (!rst_n) valid_q |-> busy_q);
    a_err_excl: assert property (
        @(posedge clk) disable iff (!rst_n) err_q |-> !xfer_ok_q);

endmodule

// File: tb/tb_bus_xfer_sched.sv
// Testbench for bus_xfer_sched: directed and random transfers
// checked against a scenario-level outcome model.
module tb_bus_xfer_sched;

    localparam int N_REQ     = 4;
    localparam int BURST_LEN = 4;
    localparam int READY_TO  = 4;
    localparam int DONE_TO   = 8;
    localparam int IDX_W     = $clog2(N_REQ);

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_REQ-1:0] req   = '0;
    logic             ready = 1'b0;
    logic             done  = 1'b0;
    logic [N_REQ-1:0] gnt;
    logic             valid;
    logic             busy;
    logic             xfer_ok;
    logic             err;
    logic [1:0]       err_code;
    logic [IDX_W-1:0] err_id;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ptr  = 0;

    always #5 clk = ~clk;

    bus_xfer_sched #(
        .N_REQ     (N_REQ),
        .BURST_LEN (BURST_LEN),
        .READY_TO  (READY_TO),
        .DONE_TO   (DONE_TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .valid    (valid),
        .ready    (ready),
        .done     (done),
        .busy     (busy),
        .xfer_ok  (xfer_ok),
        .err      (err),
        .err_code (err_code),
        .err_id   (err_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: first set bit at or after ptr.
    function automatic int pick(input logic [N_REQ-1:0] rq, input int ptr);
        int c;
        pick = -1;
        for (int i = 0; i < N_REQ; i++) begin
            c = (ptr + i) % N_REQ;
            if (pick < 0 && rq[c]) pick = c;
        end
    endfunction

    // Scenario: first ready at elapsed r_lat (>READY_TO = never),
    // ready low at burst position drop_k (0 = none), done at done_t.
    task automatic run_xfer(input logic [N_REQ-1:0] rq, input int r_lat,
                            input int drop_k, input int done_t,
                            input bit noise, input string tag);
        int w, last, exp_vcnt, exp_out, exp_code, n, e;
        bit seen;
        logic [N_REQ-1:0] exp_oh;
        logic rd, dn;
        w = pick(rq, exp_ptr);
        exp_oh = '0;
        exp_oh[w] = 1'b1;
        last = r_lat + BURST_LEN - 1;
        if (r_lat > READY_TO) begin
            exp_code = 1; exp_out = READY_TO; exp_vcnt = READY_TO;
        end else if (drop_k != 0) begin
            exp_code = 2; exp_out = r_lat + drop_k; exp_vcnt = exp_out;
        end else begin
            exp_vcnt = last;
            if (done_t <= DONE_TO) begin
                exp_code = 0; exp_out = done_t;
            end else begin
                exp_code = 3; exp_out = DONE_TO;
            end
        end

        req = rq; ready = 1'b0; done = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == '0 && n < 8);
        chk({tag, " grant latency"}, n, 1);
        chk({tag, " gnt"}, gnt, exp_oh);

        seen = 1'b0;
        e = 1;
        while (!seen && e <= DONE_TO + 3) begin
            if (err || xfer_ok) begin
                seen = 1'b1;
                chk({tag, " outcome cycle"}, e, exp_out + 1);
                chk({tag, " xfer_ok"}, xfer_ok, exp_code == 0);
                chk({tag, " err"}, err, exp_code != 0);
                if (exp_code != 0) begin
                    chk({tag, " err_code"}, err_code, exp_code);
                    chk({tag, " err_id"}, err_id, w);
                end
                chk({tag, " gnt in close"}, gnt, 0);
                chk({tag, " valid in close"}, valid, 0);
            end else begin
                chk($sformatf("%s valid@%0d", tag, e), valid, e <= exp_vcnt);
                chk($sformatf("%s gnt@%0d", tag, e), gnt, exp_oh);
                chk($sformatf("%s busy@%0d", tag, e), busy, 1);
                if (r_lat > READY_TO || e < r_lat) rd = 1'b0;
                else if (drop_k != 0 && e == r_lat + drop_k) rd = 1'b0;
                else if (e <= last) rd = 1'b1;
                else rd = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                dn = (e == done_t) ||
                     (noise && e <= last && $urandom_range(0, 1) == 1);
                ready = rd;
                done  = dn;
                @(negedge clk);
                e++;
            end
        end
        chk({tag, " outcome seen"}, seen, 1);
        ready = 1'b0; done = 1'b0;
        @(negedge clk);
        chk({tag, " idle busy"}, busy, 0);
        chk({tag, " idle gnt"}, gnt, 0);
        chk({tag, " idle pulses"}, {err, xfer_ok}, 0);
        exp_ptr = (w + 1) % N_REQ;
    endtask

    logic [N_REQ-1:0] rq;
    int kind, rl, dk, dt, w0, nw;
    logic [N_REQ-1:0] oh0;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst gnt", gnt, 0);
        chk("rst valid", valid, 0);
        chk("rst busy", busy, 0);
        chk("rst pulses", {err, xfer_ok}, 0);
        chk("rst err_code", err_code, 0);
        chk("rst err_id", err_id, 0);
        rst_n = 1'b1;
        exp_ptr = 0;

        // Clean single transfer, done two cycles after last beat
        run_xfer(4'b0001, 1, 0, BURST_LEN + 2, 1'b0, "t1");
        // All requesting: rotation continues from pointer 1
        for (int k = 0; k < 5; k++)
            run_xfer(4'b1111, 1, 0, BURST_LEN + 1, 1'b0, "t2");
        // Ready never arrives
        run_xfer(4'b0100, READY_TO + 1, 0, DONE_TO + 1, 1'b0, "t3");
        // Ready 1,1,0
        run_xfer(4'b1000, 1, 2, DONE_TO + 1, 1'b0, "t4");
        // Done withheld, then done on the last allowed cycle
        run_xfer(4'b0010, 1, 0, DONE_TO + 1, 1'b0, "t5a");
        run_xfer(4'b0010, 1, 0, DONE_TO, 1'b0, "t5b");

        // Reset during BURST
        req = 4'b0001;
        w0 = pick(req, exp_ptr);
        oh0 = '0;
        oh0[w0] = 1'b1;
        nw = 0;
        do begin
            @(negedge clk);
            nw++;
        end while (gnt == '0 && nw < 8);
        chk("t6 gnt", gnt, oh0);
        ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6 valid before rst", valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 gnt async", gnt, 0);
        chk("t6 valid async", valid, 0);
        chk("t6 busy async", busy, 0);
        chk("t6 no err", {err, xfer_ok}, 0);
        ready = 1'b0;
        req = 4'b1100;
        exp_ptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_xfer(4'b1100, 1, 0, BURST_LEN + 1, 1'b0, "t6");

        // Random transfers
        for (int k = 0; k < 40; k++) begin
            rq = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            kind = $urandom_range(0, 9);
            rl = $urandom_range(1, READY_TO);
            dk = 0;
            if (kind == 0) rl = READY_TO + 1;
            else if (kind == 1) dk = $urandom_range(1, BURST_LEN - 1);
            dt = $urandom_range(rl + BURST_LEN, DONE_TO + 1);
            run_xfer(rq, rl, dk, dt, 1'b1, $sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
